complex_frame_collector: RTL
============================

Name: complex_frame_collector

Overview:
- Sits directly downstream of the fp32 complex multiplier.
- Captures the multiplier's streaming complex products, which arrive as frames announced by the multiplier's next_out strobe, into an internal FIFO.
- Presents the products to the downstream memory writer over a valid/ready interface with an end-of-frame marker.
- Admits a frame only if the whole frame fits; otherwise drops the entire frame and records the event.

Parameters:
FRAME_LEN, 4, complex samples per frame (>=2)
DEPTH, 16, FIFO entries (power of 2, >= FRAME_LEN)
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_r  in  32  real part of product (fp32)
in_i  in  32  imaginary part of product (fp32)
next_out  in  1  frame-start strobe; first sample valid the cycle after
clear_flags  in  1  synchronous clear of frame_drop, proto_err, drop_count
out_data  out  64  {real[63:32], imag[31:0]} of FIFO head
out_valid  out  1  FIFO head valid
out_last  out  1  head is last sample of its frame
out_ready  in  1  downstream accepts head
level  out  $clog2(DEPTH)+1  current FIFO occupancy
frame_drop  out  1  sticky: at least one frame dropped
proto_err  out  1  sticky: next_out seen mid-frame
drop_count  out  CNT_W  dropped frames, saturating

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO pointers and level 0, out_valid/out_last/out_data 0, all flags and counters 0.
- FSM states:
  - IDLE: wait for a frame start.
  - CAPTURE: idx 0..FRAME_LEN-1, write in_r/in_i into the FIFO every cycle; last=1 when idx==FRAME_LEN-1.
  - DISCARD: idx counts as in CAPTURE, no writes.
- Admission decision (taken in IDLE, or in the final cycle of CAPTURE/DISCARD):
  - When next_out=1, compute projected = level + (1 if a write occurs this cycle).
  - A pop in the same cycle is ignored for this check.
  - If DEPTH - projected >= FRAME_LEN: go to CAPTURE, idx=0.
  - Else: go to DISCARD, idx=0, frame_drop<=1, drop_count increments and saturates at all-ones.
- Final-cycle transitions:
  - Final cycle of CAPTURE/DISCARD with next_out=0 -> IDLE.
  - Final cycle with next_out=1 -> new frame per the admission decision (back-to-back frames, no gap).
- next_out=1 in a non-final cycle of CAPTURE/DISCARD: ignored, proto_err<=1, current frame continues unaffected.
- Guarantee: admission ensures a CAPTURE write never finds the FIFO full, so samples are never lost mid-frame.
- FIFO read side:
  - First-word-fall-through; out_valid = (level != 0); out_data/out_last are the registered head entry.
  - Pop when out_valid && out_ready. Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - out_ready while empty: no effect.
- Latency: a sample presented in cycle t is visible on out_data with out_valid=1 in cycle t+1 if the FIFO was empty. Throughput is 1 sample/cycle in and out.
- clear_flags=1: frame_drop, proto_err and drop_count go to 0 next cycle. If a drop occurs in the same cycle, the clear wins and that drop is not counted.
- in_r/in_i are treated as opaque 32-bit fields; no fp interpretation.
- Reset mid-frame: the FIFO contents and the partial frame are discarded, FSM returns to IDLE.

Test Plan:
- Single frame: next_out at t0, samples (1.0,2.0),(3.0,4.0),(5.0,6.0),(7.0,-1.0) on t1..t4, out_ready=1 -> out_valid on t2..t5 with the same 64-bit words in order, out_last=1 only at t5, level peaks at 1.
- Back-to-back: next_out at t0 and t4, 8 samples, out_ready=0 -> both frames admitted, level=8, out_last set on entries 4 and 8; then out_ready=1 drains 8 words in order.
- Overflow: out_ready=0, DEPTH=16, four frames fill the FIFO (level=16), fifth next_out -> DISCARD, frame_drop=1, drop_count=1, level stays 16; after 4 pops, the next frame is admitted.
- Mid-frame strobe: next_out at t0 and t2 -> proto_err=1, exactly 4 samples captured, no second frame started.
- Async reset: assert reset=0 at t2 of a frame with level=3 -> outputs 0 immediately; after release, a new frame is captured correctly from an empty FIFO.
- clear_flags after 2 drops -> drop_count 0, frame_drop 0, proto_err 0 next cycle; drop_count saturation checked with CNT_W=2 after 5 drops -> 3.

Source files
------------

// File: rtl/complex_frame_collector.sv
// complex_frame_collector: frames complex products from the multiplier
// into a FWFT FIFO, admitting a frame only when the whole frame fits.
module complex_frame_collector #(
    parameter int FRAME_LEN = 4,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              in_r,
    input  logic [31:0]              in_i,
    input  logic                     next_out,
    input  logic                     clear_flags,
    output logic [63:0]              out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_drop,
    output logic                     proto_err,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DISCARD
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            frame_drop_q, frame_drop_d;
    logic            proto_err_q, proto_err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // each entry is {last, real, imag}
    logic [64:0]     mem_q [DEPTH];

    logic            frame_final;
    logic            push;
    logic            pop;
    logic [LW:0]     projected;
    logic            fits;
    logic            start;
    logic            drop_evt;
    logic            proto_evt;

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q][63:0] : 64'd0;
    assign out_last   = out_valid ? mem_q[rd_ptr_q][64] : 1'b0;
    assign level      = level_q;
    assign frame_drop = frame_drop_q;
    assign proto_err  = proto_err_q;
    assign drop_count = drop_cnt_q;

    // admission decision ignores a same-cycle pop, so capture never overflows
    always_comb begin
        frame_final = (state_q != IDLE) && (idx_q == IW'(FRAME_LEN - 1));
        push        = (state_q == CAPTURE);
        pop         = out_valid && out_ready;
        projected   = {1'b0, level_q} + {{LW{1'b0}}, push};
        fits        = (projected + (LW+1)'(FRAME_LEN)) <= (LW+1)'(DEPTH);
        start       = next_out && ((state_q == IDLE) || frame_final);
        proto_evt   = next_out && (state_q != IDLE) && !frame_final;
        drop_evt    = start && !fits;
    end

    // next-state logic for the frame FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q != IDLE) begin
            idx_d = idx_q + 1'b1;
        end
        if (frame_final) begin
            state_d = IDLE;
            idx_d   = '0;
        end
        if (start) begin
            idx_d   = '0;
            state_d = fits ? CAPTURE : DISCARD;
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // sticky flags and drop counter; a clear beats a same-cycle event
    always_comb begin
        frame_drop_d = frame_drop_q;
        proto_err_d  = proto_err_q;
        drop_cnt_d   = drop_cnt_q;
        if (clear_flags) begin
            frame_drop_d = 1'b0;
            proto_err_d  = 1'b0;
            drop_cnt_d   = '0;
        end else begin
            if (drop_evt) begin
                frame_drop_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            if (proto_evt) begin
                proto_err_d = 1'b1;
            end
        end
    end

    // control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_drop_q <= 1'b0;
            proto_err_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_drop_q <= frame_drop_d;
            proto_err_q  <= proto_err_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // sample storage; contents are don't-care while level is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {frame_final, in_r, in_i};
        end
    end

endmodule
